// File: rtl/bs_gnrtr_n_rbtr.sv
// ---------------------------------------------------------------------------
// bs_gnrtr_n_rbtr
// Shared-bus generator and arbiter. Each of `bits` independent bus lanes
// connects `drvrs` device FIFOs. A lane grants one pending device at a time
// in round-robin order, pops its head packet, and pushes that packet to the
// addressed device. A broadcast packet goes to every device except the sender.
//
// Packet format: dest ID = pkt[pckg_sz-1 -: 8]. The remaining low bits are
// payload and pass through unmodified.
//
// Ports
//   clk     in   1                            system clock, posedge
//   reset   in   1                            synchronous, active-high
//   pndng   in   [bits][drvrs]                device has a packet waiting
//   push    out  [bits][drvrs]                1-cycle strobe: accept D_push
//   pop     out  [bits][drvrs]                1-cycle strobe: drop head packet
//   D_pop   in   [bits][drvrs][pckg_sz]       head packet of each device
//   D_push  out  [bits][drvrs][pckg_sz]       packet delivered to each device
//
// Per-lane FSM
//   state | meaning
//   ARB   | scan pndng from rr; on a winner, latch its packet and raise pop
//   POP   | pop strobe visible; compute push mask and D_push for next cycle
//   PUSH  | push strobe visible; advance rr past the source
// ---------------------------------------------------------------------------
module bs_gnrtr_n_rbtr #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0]              pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  typedef logic [IW-1:0] idx_t;

  for (genvar b = 0; b < bits; b++) begin : g_lane
    state_t                        state_q, state_d;
    idx_t                          rr_q, rr_d;
    idx_t                          src_q, src_d;
    logic [pckg_sz-1:0]            pkt_q, pkt_d;
    logic [drvrs-1:0]              pop_q, pop_d;
    logic [drvrs-1:0]              push_q, push_d;
    logic [drvrs-1:0][pckg_sz-1:0] dpush_q, dpush_d;
    logic                          found;
    idx_t                          win;
    logic [7:0]                    dest;
    logic                          is_bcast;
    logic                          is_uni;

    // Round-robin scan: first pending device at or after rr, wrapping.
    always_comb begin : arb_scan
      int j;
      found = 1'b0;
      win   = '0;
      j     = 0;
      for (int i = 0; i < drvrs; i++) begin
        j = int'(rr_q) + i;
        if (j >= drvrs) j = j - drvrs;
        if (!found && pndng[b][idx_t'(j)]) begin
          found = 1'b1;
          win   = idx_t'(j);
        end
      end
    end

    always_comb begin : fsm_next
      state_d  = state_q;
      rr_d     = rr_q;
      src_d    = src_q;
      pkt_d    = pkt_q;
      pop_d    = '0;
      push_d   = '0;
      dpush_d  = dpush_q;
      dest     = pkt_q[pckg_sz-1 -: 8];
      is_bcast = (dest == broadcast);
      is_uni   = (int'(dest) < drvrs);

      unique case (state_q)
        ARB: begin
          // Packet is latched at grant time, while pndng (and so D_pop) is
          // guaranteed valid; later pndng changes cannot corrupt it.
          if (found) begin
            state_d = POP;
            src_d   = win;
            pkt_d   = D_pop[b][win];
            for (int d = 0; d < drvrs; d++) pop_d[d] = (int'(win) == d);
          end
        end
        POP: begin
          state_d = PUSH;
          for (int d = 0; d < drvrs; d++) begin
            dpush_d[d] = pkt_q;
            if (is_bcast) push_d[d] = (int'(src_q) != d);
            else          push_d[d] = is_uni && (int'(dest) == d);
          end
        end
        PUSH: begin
          state_d = ARB;
          rr_d    = (int'(src_q) == drvrs - 1) ? '0 : src_q + idx_t'(1);
        end
        default: state_d = ARB;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ARB;
        rr_q    <= '0;
        src_q   <= '0;
        pkt_q   <= '0;
        pop_q   <= '0;
        push_q  <= '0;
        dpush_q <= '0;
      end else begin
        state_q <= state_d;
        rr_q    <= rr_d;
        src_q   <= src_d;
        pkt_q   <= pkt_d;
        pop_q   <= pop_d;
        push_q  <= push_d;
        dpush_q <= dpush_d;
      end
    end

    assign pop[b]    = pop_q;
    assign push[b]   = push_q;
    assign D_push[b] = dpush_q;
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// ---------------------------------------------------------------------------
// tb_bs_gnrtr_n_rbtr
// Directed bench for the bus generator/arbiter with drvrs=6, one lane.
// A transaction-level model predicts pop/push/D_push every cycle from the
// stimulus; a compare process checks the DUT against it on each negedge, and
// the directed sequence adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_bs_gnrtr_n_rbtr;
  localparam int BITS = 1;
  localparam int DRV  = 6;
  localparam int PW   = 16;

  logic                               clk;
  logic                               reset;
  logic [BITS-1:0][DRV-1:0]           pndng;
  logic [BITS-1:0][DRV-1:0]           push;
  logic [BITS-1:0][DRV-1:0]           pop;
  logic [BITS-1:0][DRV-1:0][PW-1:0]   D_pop;
  logic [BITS-1:0][DRV-1:0][PW-1:0]   D_push;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  bs_gnrtr_n_rbtr #(.bits(BITS), .drvrs(DRV), .pckg_sz(PW), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .push(push), .pop(pop),
    .D_pop(D_pop), .D_push(D_push)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A grant decided at edge e shows pop after e, delivers after e+1, and the
  // lane may grant again at edge e+3. Reset cancels any undelivered packet.
  int          cyc = 0;
  int          next_arb = 0;
  int          deliver_edge = 0;
  bit          have_pkt = 0;
  int          m_rr = 0;
  int          m_src = 0;
  logic [15:0] m_pkt = '0;
  logic [5:0]  m_pop = '0;
  logic [5:0]  m_push = '0;
  logic [15:0] m_dpush = '0;

  always @(posedge clk) begin
    m_pop  = '0;
    m_push = '0;
    if (reset) begin
      m_rr     = 0;
      m_dpush  = '0;
      have_pkt = 0;
      next_arb = cyc + 1;
    end else begin
      if (have_pkt && cyc == deliver_edge) begin
        if (m_pkt[15:8] == 8'hFF)    m_push = 6'b111111 & ~(6'b1 << m_src);
        else if (m_pkt[15:8] < DRV)  m_push = 6'b1 << m_pkt[15:8];
        m_dpush  = m_pkt;
        m_rr     = (m_src + 1) % DRV;
        have_pkt = 0;
      end
      if (cyc >= next_arb) begin
        for (int i = 0; i < DRV; i++) begin
          int j;
          j = (m_rr + i) % DRV;
          if (!have_pkt && pndng[0][j]) begin
            m_pop[j]     = 1'b1;
            m_src        = j;
            m_pkt        = D_pop[0][j];
            have_pkt     = 1;
            deliver_edge = cyc + 1;
            next_arb     = cyc + 3;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pop", pop[0], m_pop);
      chk("model_push", push[0], m_push);
      for (int d = 0; d < DRV; d++) chk($sformatf("model_dpush%0d", d), D_push[0][d], m_dpush);
      chk("one_hot_pop", ($countones(pop[0]) <= 1), 1);
      chk("pop_push_excl", ((pop[0] != 0) && (push[0] != 0)), 0);
    end
  end

  // Wait (bounded) for a pop strobe, then require it to name device dev.
  task automatic wait_pop(input int dev, input string name);
    int n;
    logic [5:0] exp;
    n   = 0;
    exp = 6'b1 << dev;
    while (pop[0] == '0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(name, pop[0], exp);
  endtask

  int          g_dev[$];
  int          g_cyc[$];
  int          n;
  int          w;
  logic [5:0]  tmp;

  initial begin
    reset = 1;
    pndng = '0;
    D_pop = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_pop", pop[0], 6'b0);
    chk("rst_push", push[0], 6'b0);
    chk("rst_dpush", D_push[0][0], 16'h0);
    reset = 0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_strobes", {pop[0], push[0]}, 12'h0);
    end

    // unicast dev0 -> dev3
    D_pop[0][0] = 16'h03AB;
    pndng[0]    = 6'b000001;
    wait_pop(0, "u_pop0");
    pndng[0] = '0;
    @(negedge clk);
    chk("u_pop_1cyc", pop[0], 6'b0);
    chk("u_push", push[0], 6'b001000);
    chk("u_dpush3", D_push[0][3], 16'h03AB);
    @(negedge clk);
    chk("u_push_1cyc", push[0], 6'b0);
    chk("u_dpush_hold", D_push[0][3], 16'h03AB);

    // broadcast from dev2
    D_pop[0][2] = 16'hFF5A;
    pndng[0]    = 6'b000100;
    wait_pop(2, "b_pop2");
    pndng[0] = '0;
    @(negedge clk);
    chk("b_push", push[0], 6'b111011);
    chk("b_dpush0", D_push[0][0], 16'hFF5A);
    chk("b_dpush5", D_push[0][5], 16'hFF5A);

    // out-of-range destination from dev1 is discarded
    D_pop[0][1] = 16'h0977;
    pndng[0]    = 6'b000010;
    wait_pop(1, "d_pop1");
    pndng[0] = '0;
    @(negedge clk);
    chk("d_nopush", push[0], 6'b0);
    repeat (2) @(negedge clk);

    // self-addressed packet from dev4
    D_pop[0][4] = 16'h0412;
    pndng[0]    = 6'b010000;
    wait_pop(4, "s_pop4");
    pndng[0] = '0;
    @(negedge clk);
    chk("s_push", push[0], 6'b010000);
    chk("s_dpush4", D_push[0][4], 16'h0412);
    repeat (2) @(negedge clk);

    // reset during POP aborts the transfer
    D_pop[0][3] = 16'h0100;
    pndng[0]    = 6'b001000;
    wait_pop(3, "r_pop3");
    reset    = 1;
    pndng[0] = '0;
    @(negedge clk);
    chk("r_strobes", {pop[0], push[0]}, 12'h0);
    chk("r_dpush", D_push[0][1], 16'h0);

    // fairness: everyone pending continuously, rr restarts at 0
    for (int d = 0; d < DRV; d++) D_pop[0][d] = {8'((d + 1) % DRV), 8'(d)};
    pndng[0] = 6'b111111;
    reset    = 0;
    n = 0;
    while (g_dev.size() < 7 && n < 40) begin
      @(negedge clk);
      n++;
      if (pop[0] != 0) begin
        tmp = pop[0];
        w   = 0;
        for (int d = 0; d < DRV; d++) if (tmp[d]) w = d;
        g_dev.push_back(w);
        g_cyc.push_back(n);
      end
    end
    chk("f_count", g_dev.size(), 7);
    for (int k = 0; k < g_dev.size(); k++) chk($sformatf("f_order%0d", k), g_dev[k], k % DRV);
    for (int k = 1; k < g_cyc.size(); k++) chk($sformatf("f_space%0d", k), g_cyc[k] - g_cyc[k-1], 3);
    pndng[0] = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
